// File: rtl/text_console_ctrl.sv
// text_console_ctrl
//   Minimal glass-terminal sequencer: turns an ASCII byte stream into
//   character_buffer write commands and owns the cursor. Handles printable
//   characters, CR, LF, BS and FF, wraps at line and screen end, and blanks
//   rows / the whole screen with back-to-back space writes.
//   Screen dimensions are expected to be at least 2x2.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   in_valid/in_data  incoming byte, accepted when in_valid && in_ready
//   in_ready          high only in IDLE (state-derived)
//   char_*            registered write command to character_buffer
//   cursor_*          registered cursor position, cursor_en high in IDLE
//   busy              a row or screen clear is in progress
module text_console_ctrl #(
   parameter int unsigned CHAR_HORZ_CNT = 80,
   parameter int unsigned CHAR_VERT_CNT = 30,
   parameter int unsigned CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
   parameter int unsigned CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   output logic [CHAR_HORZ_W-1:0] char_hpos,
   output logic [CHAR_VERT_W-1:0] char_vpos,
   output logic                   char_write_en,
   output logic [7:0]             char_symbol,
   output logic                   cursor_en,
   output logic [CHAR_HORZ_W-1:0] cursor_hpos,
   output logic [CHAR_VERT_W-1:0] cursor_vpos,
   output logic                   busy
);

   localparam logic [CHAR_HORZ_W-1:0] COL_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
   localparam logic [CHAR_VERT_W-1:0] ROW_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
   localparam logic [CHAR_HORZ_W-1:0] COL_ONE  = CHAR_HORZ_W'(1);
   localparam logic [CHAR_VERT_W-1:0] ROW_ONE  = CHAR_VERT_W'(1);

   localparam logic [7:0] ASCII_SP    = 8'h20;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_FF    = 8'h0C;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLR_ROW = 2'd1,
      S_CLR_ALL = 2'd2
   } state_t;

   state_t                 state_q;
   logic [CHAR_HORZ_W-1:0] cur_col_q;
   logic [CHAR_VERT_W-1:0] cur_row_q;
   logic [CHAR_HORZ_W-1:0] clr_col_q;
   logic [CHAR_VERT_W-1:0] clr_row_q;
   logic                   clr_done_q;
   logic                   wr_en_q;
   logic [CHAR_HORZ_W-1:0] wr_col_q;
   logic [CHAR_VERT_W-1:0] wr_row_q;
   logic [7:0]             wr_sym_q;

   logic                   printable_c;
   logic [CHAR_VERT_W-1:0] row_next_c;
   logic [CHAR_HORZ_W-1:0] col_prev_c;

   // Byte classification and cursor arithmetic shared by the IDLE decode
   assign printable_c = (in_data >= ASCII_SP) && (in_data <= ASCII_TILDE);
   assign row_next_c  = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + ROW_ONE;
   assign col_prev_c  = cur_col_q - COL_ONE;

   // Handshake / status are decoded straight from the state register
   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign cursor_en = (state_q == S_IDLE);

   assign char_write_en = wr_en_q;
   assign char_hpos     = wr_col_q;
   assign char_vpos     = wr_row_q;
   assign char_symbol   = wr_sym_q;
   assign cursor_hpos   = cur_col_q;
   assign cursor_vpos   = cur_row_q;

   // Sequencer: byte decode in IDLE, space-fill sweeps in the clear states.
   // A clear sweep emits one write per cycle and uses clr_done_q to spend one
   // extra cycle busy after the last write, so in_ready returns the cycle after it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_CLR_ALL;
         cur_col_q  <= '0;
         cur_row_q  <= '0;
         clr_col_q  <= '0;
         clr_row_q  <= '0;
         clr_done_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_col_q   <= '0;
         wr_row_q   <= '0;
         wr_sym_q   <= '0;
      end else begin
         wr_en_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  if (printable_c) begin
                     wr_en_q  <= 1'b1;
                     wr_col_q <= cur_col_q;
                     wr_row_q <= cur_row_q;
                     wr_sym_q <= in_data;
                     if (cur_col_q != COL_LAST) begin
                        cur_col_q <= cur_col_q + COL_ONE;
                     end else begin
                        // Wrap: the character write takes this slot, the row sweep starts next
                        cur_col_q  <= '0;
                        cur_row_q  <= row_next_c;
                        clr_col_q  <= '0;
                        clr_done_q <= 1'b0;
                        state_q    <= S_CLR_ROW;
                     end
                  end else if (in_data == ASCII_LF) begin
                     // No character write, so the first blanking write goes out immediately
                     cur_col_q  <= '0;
                     cur_row_q  <= row_next_c;
                     wr_en_q    <= 1'b1;
                     wr_col_q   <= '0;
                     wr_row_q   <= row_next_c;
                     wr_sym_q   <= ASCII_SP;
                     clr_col_q  <= COL_ONE;
                     clr_done_q <= 1'b0;
                     state_q    <= S_CLR_ROW;
                  end else if (in_data == ASCII_CR) begin
                     cur_col_q <= '0;
                  end else if (in_data == ASCII_BS) begin
                     if (cur_col_q != '0) begin
                        cur_col_q <= col_prev_c;
                        wr_en_q   <= 1'b1;
                        wr_col_q  <= col_prev_c;
                        wr_row_q  <= cur_row_q;
                        wr_sym_q  <= ASCII_SP;
                     end
                  end else if (in_data == ASCII_FF) begin
                     // First cell (0,0) is written now; the sweep continues from (1,0)
                     cur_col_q  <= '0;
                     cur_row_q  <= '0;
                     wr_en_q    <= 1'b1;
                     wr_col_q   <= '0;
                     wr_row_q   <= '0;
                     wr_sym_q   <= ASCII_SP;
                     clr_col_q  <= COL_ONE;
                     clr_row_q  <= '0;
                     clr_done_q <= 1'b0;
                     state_q    <= S_CLR_ALL;
                  end
               end
            end

            S_CLR_ROW: begin
               if (clr_done_q) begin
                  state_q <= S_IDLE;
               end else begin
                  wr_en_q  <= 1'b1;
                  wr_col_q <= clr_col_q;
                  wr_row_q <= cur_row_q;
                  wr_sym_q <= ASCII_SP;
                  if (clr_col_q == COL_LAST) begin
                     clr_done_q <= 1'b1;
                  end else begin
                     clr_col_q <= clr_col_q + COL_ONE;
                  end
               end
            end

            S_CLR_ALL: begin
               if (clr_done_q) begin
                  state_q <= S_IDLE;
               end else begin
                  wr_en_q  <= 1'b1;
                  wr_col_q <= clr_col_q;
                  wr_row_q <= clr_row_q;
                  wr_sym_q <= ASCII_SP;
                  if (clr_col_q == COL_LAST) begin
                     clr_col_q <= '0;
                     if (clr_row_q == ROW_LAST) begin
                        clr_done_q <= 1'b1;
                     end else begin
                        clr_row_q <= clr_row_q + ROW_ONE;
                     end
                  end else begin
                     clr_col_q <= clr_col_q + COL_ONE;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
